// File: rtl/slave_rx.sv
// slave_rx: oversampled serial byte receiver that locks onto an incrementing byte stream.
// Define SLAVE_RX_ERRCNT_EN to build the saturating out-of-sequence counter behind err_cnt.
module slave_rx #(
  parameter int BIT_DIV    = 100000002,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       mosi,
  output logic [7:0] data,
  output logic       valid,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam int            TW         = 27;
  localparam logic [TW-1:0] DIV_LAST   = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] DIV_HALF   = TW'(BIT_DIV / 2);
  localparam logic [7:0]    LOCK_TGT   = 8'(LOCK_CNT);
  localparam logic [7:0]    UNLOCK_TGT = 8'(UNLOCK_CNT);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic          mosi_meta_r;
  logic          mosi_sync_r;
  logic          mosi_prev_r;
  logic [TW-1:0] timer_r;
  logic [3:0]    slot_r;
  logic          slip_r;
  logic [6:0]    shift_r;
  logic [1:0]    state_r;
  logic [7:0]    ref_r;
  logic [7:0]    match_r;
  logic [7:0]    miss_r;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          locked_r;

  logic          mosi_edge_s;
  logic          sample_s;
  logic          done_s;
  logic          in_seq_s;
  logic          slip_set_s;
  logic [7:0]    byte_s;

  assign mosi_edge_s = mosi_sync_r ^ mosi_prev_r;
  assign sample_s    = (timer_r == DIV_HALF);
  assign done_s      = sample_s && !slip_r && (slot_r == 4'd7);
  assign byte_s      = {mosi_sync_r, shift_r};
  assign in_seq_s    = (byte_s == (ref_r + 8'd1));
  assign slip_set_s  = done_s && (state_r == ST_CHECK) && !in_seq_s;

  // Synchronizer plus a delayed copy for transition detection
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      mosi_prev_r <= 1'b0;
    end else begin
      mosi_meta_r <= mosi;
      mosi_sync_r <= mosi_meta_r;
      mosi_prev_r <= mosi_sync_r;
    end
  end

  // Bit timer, realigned to every line transition
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      timer_r <= '0;
    end else if (mosi_edge_s || (timer_r == DIV_LAST)) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + 27'd1;
    end
  end

  // Slot counter and data shifter; a pending slip swallows one sample point
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      slot_r  <= 4'd0;
      slip_r  <= 1'b0;
      shift_r <= 7'd0;
    end else if (sample_s) begin
      if (slip_r) begin
        slip_r <= 1'b0;
      end else begin
        slip_r <= slip_set_s;
        slot_r <= (slot_r == 4'd8) ? 4'd0 : slot_r + 4'd1;
        if (slot_r < 4'd7) begin
          shift_r <= {mosi_sync_r, shift_r[6:1]};
        end else begin
          shift_r <= shift_r;
        end
      end
    end else begin
      slip_r <= slip_r;
    end
  end

  // Lock FSM; the locking byte itself is already delivered with valid
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_HUNT;
      ref_r    <= 8'h00;
      match_r  <= 8'd0;
      miss_r   <= 8'd0;
      data_r   <= 8'h00;
      valid_r  <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (done_s) begin
        case (state_r)
          ST_HUNT: begin
            ref_r   <= byte_s;
            match_r <= 8'd1;
            state_r <= ST_CHECK;
          end
          ST_CHECK: begin
            if (in_seq_s) begin
              ref_r   <= byte_s;
              match_r <= match_r + 8'd1;
              if ((match_r + 8'd1) >= LOCK_TGT) begin
                state_r  <= ST_LOCKED;
                locked_r <= 1'b1;
                miss_r   <= 8'd0;
                data_r   <= byte_s;
                valid_r  <= 1'b1;
              end else begin
                state_r <= ST_CHECK;
              end
            end else begin
              match_r <= 8'd0;
              state_r <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            // The reference free-runs so a single corrupted byte does not break the sequence
            ref_r <= ref_r + 8'd1;
            if (in_seq_s) begin
              miss_r  <= 8'd0;
              data_r  <= byte_s;
              valid_r <= 1'b1;
            end else if ((miss_r + 8'd1) >= UNLOCK_TGT) begin
              miss_r   <= 8'd0;
              state_r  <= ST_HUNT;
              locked_r <= 1'b0;
            end else begin
              miss_r  <= miss_r + 8'd1;
              data_r  <= byte_s;
              valid_r <= 1'b1;
            end
          end
          default: begin
            state_r  <= ST_HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign data   = data_r;
  assign valid  = valid_r;
  assign locked = locked_r;

`ifdef SLAVE_RX_ERRCNT_EN
  logic [7:0] err_cnt_r;
  logic       miss_err_s;

  assign miss_err_s = done_s && (state_r == ST_LOCKED) && !in_seq_s;

  // Saturating out-of-sequence counter, cleared only by reset
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      err_cnt_r <= 8'h00;
    end else if (miss_err_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_slave_rx.sv
// tb_slave_rx: directed and randomized bit-stream stimulus for slave_rx, checked slot by slot
// against a frame-level reference model of the lock/unlock rules.
module tb_slave_rx;

  localparam int BD     = 10;
  localparam int LOCK_N = 3;
  localparam int UNLK_N = 2;
`ifdef SLAVE_RX_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       sclk  = 1'b0;
  logic       reset = 1'b0;
  logic       mosi  = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       locked;
  logic [7:0] err_cnt;

  slave_rx #(.BIT_DIV(BD), .LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNLK_N)) dut (
    .sclk   (sclk),
    .reset  (reset),
    .mosi   (mosi),
    .data   (data),
    .valid  (valid),
    .locked (locked),
    .err_cnt(err_cnt)
  );

  always #5 sclk = ~sclk;

  int n_vec  = 0;
  int n_err  = 0;
  int vcount = 0;
  int vlast  = 0;

  always @(negedge sclk) begin
    if (valid === 1'b1) vcount <= vcount + 1;
  end

  // Reference model state: receiver slot position plus lock rules
  int         m_mode;   // 0 hunt, 1 check, 2 locked
  int         m_slot;
  bit         m_hold;
  logic [7:0] m_acc;
  logic [7:0] m_ref;
  int         m_match;
  int         m_miss;
  int         m_err;
  logic [7:0] m_data;
  bit         m_locked;
  bit         m_vpulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_err();
    return ERR_EN ? 8'(m_err) : 8'h00;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_hold = 1'b0; m_acc = 8'h00; m_ref = 8'h00;
    m_match = 0; m_miss = 0; m_err = 0; m_data = 8'h00; m_locked = 1'b0; m_vpulse = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] nxt;
    nxt = m_ref + 8'd1;
    case (m_mode)
      0: begin
        m_ref = b; m_match = 1; m_mode = 1;
      end
      1: begin
        if (b == nxt) begin
          m_ref = b; m_match++;
          if (m_match == LOCK_N) begin
            m_mode = 2; m_locked = 1'b1; m_miss = 0; m_data = b; m_vpulse = 1'b1;
          end
        end else begin
          m_match = 0; m_mode = 0; m_hold = 1'b1;
        end
      end
      default: begin
        m_ref = nxt;
        if (b == nxt) begin
          m_miss = 0; m_data = b; m_vpulse = 1'b1;
        end else begin
          if (m_err < 255) m_err++;
          m_miss++;
          if (m_miss == UNLK_N) begin
            m_mode = 0; m_locked = 1'b0; m_miss = 0;
          end else begin
            m_data = b; m_vpulse = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic model_slot(input logic b);
    m_vpulse = 1'b0;
    if (m_hold) begin
      m_hold = 1'b0;
    end else begin
      if (m_slot < 8) m_acc[m_slot] = b;
      if (m_slot == 7) model_byte(m_acc);
      m_slot = (m_slot == 8) ? 0 : m_slot + 1;
    end
  endtask

  task automatic send_slot(input logic b);
    mosi = b;
    repeat (BD) @(posedge sclk);
    #1;
    model_slot(b);
    chk("valid_pulses", 32'(vcount - vlast), {31'd0, m_vpulse});
    vlast = vcount;
    chk("data", {24'd0, data}, {24'd0, m_data});
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("err_cnt", {24'd0, err_cnt}, {24'd0, exp_err()});
  endtask

  task automatic send_byte(input logic [7:0] v, input logic gap);
    for (int i = 0; i < 8; i++) send_slot(v[i]);
    send_slot(gap);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    model_reset();
    vlast = vcount;
    reset = 1'b1;
  endtask

  initial begin
    int         v0;
    int         fr;
    logic [7:0] v;
    logic [7:0] b33;

    // Aligned 0x01..0x05: lock on the third byte
    do_reset();
    v0 = vcount;
    for (int k = 1; k <= 3; k++) send_byte(8'(k), 1'b1);
    chk("lock_after_3", {31'd0, locked}, 32'd1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    chk("seq_valids", 32'(vcount - v0), 32'd3);
    chk("seq_data", {24'd0, data}, 32'h05);

    // Wrap-around 0xFF -> 0x00 is in sequence
    do_reset();
    send_byte(8'hFB, 1'b1); send_byte(8'hFC, 1'b1); send_byte(8'hFD, 1'b1);
    v0 = vcount;
    send_byte(8'hFE, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    chk("wrap_valids", 32'(vcount - v0), 32'd4);
    chk("wrap_err", {24'd0, err_cnt}, 32'd0);
    chk("wrap_locked", {31'd0, locked}, 32'd1);

    // Isolated miss keeps lock; two consecutive misses drop it
    do_reset();
    send_byte(8'h0E, 1'b1); send_byte(8'h0F, 1'b1); send_byte(8'h10, 1'b1);
    v0 = vcount;
    send_byte(8'h55, 1'b1); send_byte(8'h12, 1'b1);
    chk("miss1_err", {24'd0, err_cnt}, ERR_EN ? 32'd1 : 32'd0);
    chk("miss1_locked", {31'd0, locked}, 32'd1);
    send_byte(8'h77, 1'b1); send_byte(8'h99, 1'b1);
    chk("unlock_err", {24'd0, err_cnt}, ERR_EN ? 32'd3 : 32'd0);
    chk("unlock_locked", {31'd0, locked}, 32'd0);
    chk("unlock_valids", 32'(vcount - v0), 32'd3);
    chk("unlock_data", {24'd0, data}, 32'h77);

    // Reset in the middle of slot 4 while locked, then relock on a fresh stream
    do_reset();
    send_byte(8'h30, 1'b1); send_byte(8'h31, 1'b1); send_byte(8'h32, 1'b1);
    b33 = 8'h33;
    for (int i = 0; i < 4; i++) send_slot(b33[i]);
    mosi = b33[4];
    repeat (4) @(posedge sclk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_err", {24'd0, err_cnt}, 32'd0);
    model_reset();
    @(posedge sclk);
    #1;
    vlast = vcount;
    reset = 1'b1;
    v0 = vcount;
    send_byte(8'h20, 1'b1); send_byte(8'h21, 1'b1);
    chk("relock_no_valid", 32'(vcount - v0), 32'd0);
    send_byte(8'h22, 1'b1);
    chk("relock_valid", 32'(vcount - v0), 32'd1);
    chk("relock_data", {24'd0, data}, 32'h22);

    // Stream offset by 4 slots: slips until aligned, then lock within bound
    do_reset();
    for (int i = 0; i < 4; i++) send_slot(1'b0);
    fr = 0;
    while ((fr < 9 * (LOCK_N + 1)) && (locked !== 1'b1)) begin
      send_byte(8'(8'h40 + fr), 1'b1);
      fr++;
    end
    chk("offset_locked", {31'd0, locked}, 32'd1);
    send_byte(8'(8'h40 + fr), 1'b1);
    chk("offset_inc", {24'd0, data}, 32'(8'(8'h40 + fr)));

    // Randomized streams: random slot offset, mostly incrementing bytes with random glitches
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < $urandom_range(0, 8); i++) send_slot(1'($urandom_range(0, 1)));
      v = 8'($urandom_range(0, 255));
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 7) == 0) v = 8'($urandom_range(0, 255));
        else v = v + 8'd1;
        send_byte(v, 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
